// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Types shared between the traffic-light controller and its sensor conditioner.
//   light_t   : controller light encoding (3 is unused and counts as not GREEN)
//   sens_st_t : per-road sensor channel state
//   max2      : elaboration-time helper used to size shared counters
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2
  } light_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUAL    = 3'd1,
    PRESENT = 3'd2,
    GAP     = 3'd3,
    MAXOUT  = 3'd4
  } sens_st_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/traffic_sensor_cond_channel.sv
// sensor_channel
//   One road's detector conditioner: two-flop synchroniser, debounce/gap-stretch
//   FSM and a green-time counter that forces a release once the road's own light
//   has been GREEN for MAX_GREEN cycles while presence is held.
//   Ports:
//     clk   in  1  system clock, rising edge
//     rst   in  1  synchronous active-high reset
//     raw   in  1  raw detector line, asynchronous
//     light in  2  this road's controller light (light_t encoding)
//     t     out 1  conditioned presence (registered)
module sensor_channel
  import traffic_pkg::*;
#(
  parameter int DEB_CYC   = 3,
  parameter int GAP_CYC   = 4,
  parameter int MAX_GREEN = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw,
  input  logic [1:0] light,
  output logic       t
);

  localparam int CNT_W  = $clog2(max2(DEB_CYC, GAP_CYC) + 1);
  localparam int GCNT_W = $clog2(MAX_GREEN + 1);

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [GCNT_W-1:0] GCNT_ZERO = {GCNT_W{1'b0}};
  localparam logic [GCNT_W-1:0] GCNT_ONE  = GCNT_W'(1);
  localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(MAX_GREEN - 1);
  localparam logic [GCNT_W-1:0] GCNT_MAX  = GCNT_W'(MAX_GREEN);

  logic              s1_q;
  logic              s2_q;
  sens_st_t          state_q;
  sens_st_t          state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [GCNT_W-1:0] gcnt_q;
  logic [GCNT_W-1:0] gcnt_d;
  logic              t_q;
  logic              t_d;

  logic green_s;
  logic holding_s;
  logic maxout_hit_s;

  // Next-state, debounce/gap counter and green-time counter.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gcnt_d       = gcnt_q;
    green_s      = (light == GREEN);
    holding_s    = (state_q == PRESENT) || (state_q == GAP);
    // Forced release wins over every other transition on this edge.
    maxout_hit_s = green_s && holding_s && (gcnt_q == GCNT_LAST);

    if (maxout_hit_s) begin
      state_d = MAXOUT;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          if (s2_q) begin
            if (DEB_CYC == 1) begin
              state_d = PRESENT;
              cnt_d   = CNT_ZERO;
            end else begin
              state_d = QUAL;
              cnt_d   = CNT_ONE;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
          end
        end
        QUAL: begin
          if (!s2_q) begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == DEB_LAST) begin
            state_d = PRESENT;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = QUAL;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        PRESENT: begin
          if (!s2_q) begin
            if (GAP_CYC == 1) begin
              state_d = IDLE;
              cnt_d   = CNT_ZERO;
            end else begin
              state_d = GAP;
              cnt_d   = CNT_ONE;
            end
          end else begin
            state_d = PRESENT;
            cnt_d   = CNT_ZERO;
          end
        end
        GAP: begin
          if (s2_q) begin
            state_d = PRESENT;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == GAP_LAST) begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = GAP;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        MAXOUT: begin
          // Detector is ignored until our own light leaves GREEN.
          if (!green_s) begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = MAXOUT;
            cnt_d   = CNT_ZERO;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end

    if (!green_s) begin
      gcnt_d = GCNT_ZERO;
    end else if (maxout_hit_s) begin
      gcnt_d = GCNT_ZERO;
    end else if (holding_s) begin
      if (gcnt_q < GCNT_MAX) begin
        gcnt_d = gcnt_q + GCNT_ONE;
      end else begin
        gcnt_d = gcnt_q;
      end
    end else begin
      gcnt_d = gcnt_q;
    end

    // T decodes the next state so it lines up with the state register.
    t_d = (state_d == PRESENT) || (state_d == GAP);
  end

  // Synchroniser, state, counters and output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      gcnt_q  <= GCNT_ZERO;
      t_q     <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      t_q     <= t_d;
    end
  end

  assign t = t_q;

endmodule

// File: rtl/traffic_sensor_cond.sv
// traffic_sensor_cond
//   Conditions the raw vehicle detectors of roads A and B into the Ta/Tb presence
//   inputs of the traffic-light controller. The two roads are independent copies
//   of sensor_channel, each fed back with its own controller light.
//   Ports:
//     clk   in  1  system clock, rising edge
//     rst   in  1  synchronous active-high reset
//     raw_a in  1  raw detector, road A (asynchronous, may bounce)
//     raw_b in  1  raw detector, road B (asynchronous, may bounce)
//     La    in  2  controller light, road A (GREEN=0, YELLOW=1, RED=2)
//     Lb    in  2  controller light, road B
//     Ta    out 1  conditioned presence, road A
//     Tb    out 1  conditioned presence, road B
module traffic_sensor_cond
  import traffic_pkg::*;
#(
  parameter int DEB_CYC   = 3,
  parameter int GAP_CYC   = 4,
  parameter int MAX_GREEN = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_a,
  input  logic       raw_b,
  input  logic [1:0] La,
  input  logic [1:0] Lb,
  output logic       Ta,
  output logic       Tb
);

  sensor_channel #(
    .DEB_CYC   (DEB_CYC),
    .GAP_CYC   (GAP_CYC),
    .MAX_GREEN (MAX_GREEN)
  ) u_chan_a (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw_a),
    .light (La),
    .t     (Ta)
  );

  sensor_channel #(
    .DEB_CYC   (DEB_CYC),
    .GAP_CYC   (GAP_CYC),
    .MAX_GREEN (MAX_GREEN)
  ) u_chan_b (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw_b),
    .light (Lb),
    .t     (Tb)
  );

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// tb_traffic_sensor_cond
//   Directed scenarios plus a randomized run for traffic_sensor_cond, checked
//   against a run-length reference model of the presence rules.
module tb_traffic_sensor_cond;

  localparam int DEB_CYC   = 3;
  localparam int GAP_CYC   = 4;
  localparam int MAX_GREEN = 20;

  localparam logic [1:0] LG = 2'd0;
  localparam logic [1:0] LY = 2'd1;
  localparam logic [1:0] LR = 2'd2;

  logic       clk;
  logic       rst;
  logic       raw_a;
  logic       raw_b;
  logic [1:0] La;
  logic [1:0] Lb;
  logic       Ta;
  logic       Tb;

  int checks;
  int errors;

  // Reference model state per road: sync pipe, presence, maxed-out flag,
  // length of the current run of samples arguing for a change, green time.
  logic m_s1 [2];
  logic m_s2 [2];
  logic m_p  [2];
  logic m_mx [2];
  int   m_run[2];
  int   m_gt [2];

  traffic_sensor_cond #(
    .DEB_CYC   (DEB_CYC),
    .GAP_CYC   (GAP_CYC),
    .MAX_GREEN (MAX_GREEN)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .raw_a (raw_a),
    .raw_b (raw_b),
    .La    (La),
    .Lb    (Lb),
    .Ta    (Ta),
    .Tb    (Tb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input int c, input logic r, input logic [1:0] l, input logic rs);
    logic green;
    logic was_p;
    logic forced;
    if (rs) begin
      m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_p[c] = 1'b0; m_mx[c] = 1'b0;
      m_run[c] = 0; m_gt[c] = 0;
    end else begin
      green  = (l == LG);
      was_p  = m_p[c];
      forced = 1'b0;
      if (m_mx[c]) begin
        if (!green) begin
          m_mx[c] = 1'b0;
          m_run[c] = 0;
        end
      end else if (was_p && green && m_gt[c] == MAX_GREEN - 1) begin
        forced = 1'b1;
        m_mx[c] = 1'b1;
        m_p[c] = 1'b0;
        m_run[c] = 0;
      end else if (!was_p) begin
        // Absent: need DEB_CYC consecutive high samples.
        if (m_s2[c]) begin
          m_run[c]++;
          if (m_run[c] == DEB_CYC) begin m_p[c] = 1'b1; m_run[c] = 0; end
        end else m_run[c] = 0;
      end else begin
        // Present: need GAP_CYC consecutive low samples.
        if (!m_s2[c]) begin
          m_run[c]++;
          if (m_run[c] == GAP_CYC) begin m_p[c] = 1'b0; m_run[c] = 0; end
        end else m_run[c] = 0;
      end
      if (!green || forced) m_gt[c] = 0;
      else if (was_p && m_gt[c] < MAX_GREEN) m_gt[c]++;
      m_s2[c] = m_s1[c];
      m_s1[c] = r;
    end
  endtask

  // One clock: drive on the falling edge, advance model at the rising edge,
  // leave time 1ns after the edge for the caller to sample.
  task automatic cycle(input logic ra, input logic rb, input logic [1:0] la,
                       input logic [1:0] lb, input logic rs);
    @(negedge clk);
    raw_a = ra; raw_b = rb; La = la; Lb = lb; rst = rs;
    @(posedge clk);
    model_step(0, ra, la, rs);
    model_step(1, rb, lb, rs);
    #1;
  endtask

  // Drive raw_a high with fixed lights and report the edges where Ta rose and fell.
  task automatic run_high_a(input int n, input logic [1:0] la, output int rise, output int fall);
    rise = -1;
    fall = -1;
    for (int e = 1; e <= n; e++) begin
      cycle(1'b1, 1'b0, la, LR, 1'b0);
      if (rise < 0 && Ta === 1'b1) rise = e;
      else if (rise >= 0 && fall < 0 && Ta === 1'b0) fall = e;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, LR, LR, 1'b1);
      checks++;
      if (Ta !== 1'b0 || Tb !== 1'b0)
        begin errors++; $display("FAIL reset_hold: Ta=%b Tb=%b expected 0 0", Ta, Tb); end
    end
    for (int e = 1; e <= 8; e++) begin
      cycle(1'b1, 1'b1, LR, LR, 1'b0);
      checks++;
      if (Ta !== (e >= 5) || Tb !== (e >= 5))
        begin errors++; $display("FAIL reset_release edge %0d: Ta=%b Tb=%b expected %b", e, Ta, Tb, e >= 5); end
    end
  endtask

  task automatic test_debounce();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, LR, LR, 1'b0);
    checks++;
    if (Ta !== 1'b0) begin errors++; $display("FAIL deb_drain: Ta=%b expected 0", Ta); end
    // Two-cycle pulse must be rejected.
    for (int e = 1; e <= 12; e++) begin
      cycle(e <= 2, 1'b0, LR, LR, 1'b0);
      checks++;
      if (Ta !== 1'b0) begin errors++; $display("FAIL deb_short edge %0d: Ta=%b expected 0", e, Ta); end
    end
    // Three-cycle pulse: rise at edge 5, held 4 cycles by gap stretch.
    for (int e = 1; e <= 12; e++) begin
      cycle(e <= 3, 1'b0, LR, LR, 1'b0);
      checks++;
      if (Ta !== (e >= 5 && e <= 8))
        begin errors++; $display("FAIL deb_pulse3 edge %0d: Ta=%b expected %b", e, Ta, e >= 5 && e <= 8); end
    end
  endtask

  task automatic test_gap();
    for (int e = 1; e <= 8; e++) cycle(1'b1, 1'b0, LR, LR, 1'b0);
    checks++;
    if (Ta !== 1'b1) begin errors++; $display("FAIL gap_setup: Ta=%b expected 1", Ta); end
    for (int e = 1; e <= 9; e++) begin
      cycle(e > 3, 1'b0, LR, LR, 1'b0);
      checks++;
      if (Ta !== 1'b1) begin errors++; $display("FAIL gap_short edge %0d: Ta=%b expected 1", e, Ta); end
    end
    for (int e = 1; e <= 8; e++) begin
      cycle(1'b0, 1'b0, LR, LR, 1'b0);
      checks++;
      if (Ta !== (e < 6)) begin errors++; $display("FAIL gap_long edge %0d: Ta=%b expected %b", e, Ta, e < 6); end
    end
  endtask

  task automatic test_maxout();
    int rise;
    int fall;
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, LG, LR, 1'b0);
    run_high_a(40, LG, rise, fall);
    checks++;
    if (rise !== 5) begin errors++; $display("FAIL maxout_rise: edge=%0d expected 5", rise); end
    checks++;
    if (fall - rise !== MAX_GREEN)
      begin errors++; $display("FAIL maxout_len: fall-rise=%0d expected %0d", fall - rise, MAX_GREEN); end
    for (int e = 1; e <= 10; e++) begin
      cycle(1'b1, 1'b0, LG, LR, 1'b0);
      checks++;
      if (Ta !== 1'b0) begin errors++; $display("FAIL maxout_hold edge %0d: Ta=%b expected 0", e, Ta); end
    end
    for (int e = 1; e <= 6; e++) begin
      cycle(1'b1, 1'b0, LY, LR, 1'b0);
      checks++;
      if (Ta !== (e >= 4)) begin errors++; $display("FAIL maxout_rearm edge %0d: Ta=%b expected %b", e, Ta, e >= 4); end
    end
  endtask

  task automatic test_independence();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, LR, LR, 1'b0);
    for (int e = 1; e <= 32; e++) begin
      cycle(1'b1, 1'b1, LG, LR, 1'b0);
      checks++;
      if (Ta !== m_p[0] || Tb !== m_p[1])
        begin errors++; $display("FAIL indep_model edge %0d: Ta=%b Tb=%b expected %b %b", e, Ta, Tb, m_p[0], m_p[1]); end
      if (e <= 20) begin
        checks++;
        if (Ta !== Tb || Ta !== (e >= 5))
          begin errors++; $display("FAIL indep_simul edge %0d: Ta=%b Tb=%b expected %b", e, Ta, Tb, e >= 5); end
      end
    end
    checks++;
    if (Ta !== 1'b0 || Tb !== 1'b1)
      begin errors++; $display("FAIL indep_maxout: Ta=%b Tb=%b expected 0 1", Ta, Tb); end
  endtask

  task automatic test_reset_mid();
    int rise;
    int fall;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, LR, LR, 1'b0);
    // Build up green time in PRESENT, then enter GAP.
    for (int e = 1; e <= 8; e++) cycle(1'b1, 1'b0, LG, LR, 1'b0);
    for (int e = 1; e <= 3; e++) cycle(1'b0, 1'b0, LG, LR, 1'b0);
    checks++;
    if (Ta !== 1'b1) begin errors++; $display("FAIL rst_gap_setup: Ta=%b expected 1", Ta); end
    cycle(1'b0, 1'b0, LG, LR, 1'b1);
    checks++;
    if (Ta !== 1'b0) begin errors++; $display("FAIL rst_gap: Ta=%b expected 0", Ta); end
    // Full green allowance afterwards shows the green counter was cleared.
    run_high_a(30, LG, rise, fall);
    checks++;
    if (rise !== 5 || fall !== 25)
      begin errors++; $display("FAIL rst_gap_after: rise=%0d fall=%0d expected 5 25", rise, fall); end
    cycle(1'b1, 1'b0, LG, LR, 1'b1);
    checks++;
    if (Ta !== 1'b0) begin errors++; $display("FAIL rst_maxout: Ta=%b expected 0", Ta); end
    run_high_a(30, LG, rise, fall);
    checks++;
    if (rise !== 5 || fall !== 25)
      begin errors++; $display("FAIL rst_maxout_after: rise=%0d fall=%0d expected 5 25", rise, fall); end
  endtask

  task automatic test_random();
    int   la_len;
    int   lb_len;
    int   ra_len;
    int   rb_len;
    logic ra_v;
    logic rb_v;
    logic [1:0] la_v;
    logic [1:0] lb_v;
    ra_len = 0; rb_len = 0; la_len = 0; lb_len = 0;
    ra_v = 1'b0; rb_v = 1'b0; la_v = LR; lb_v = LR;
    for (int i = 0; i < 4000; i++) begin
      if (ra_len == 0) begin ra_v = ~ra_v; ra_len = $urandom_range(1, 9); end
      if (rb_len == 0) begin rb_v = ~rb_v; rb_len = $urandom_range(1, 9); end
      if (la_len == 0) begin
        la_v = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : LG;
        la_len = $urandom_range(1, 40);
      end
      if (lb_len == 0) begin
        lb_v = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : LG;
        lb_len = $urandom_range(1, 40);
      end
      ra_len--; rb_len--; la_len--; lb_len--;
      cycle(ra_v, rb_v, la_v, lb_v, $urandom_range(0, 399) == 0);
      checks++;
      if (Ta !== m_p[0] || Tb !== m_p[1])
        begin errors++; $display("FAIL random cycle %0d: Ta=%b Tb=%b expected %b %b", i, Ta, Tb, m_p[0], m_p[1]); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; raw_a = 1'b0; raw_b = 1'b0; La = LR; Lb = LR;
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_p[c] = 1'b0; m_mx[c] = 1'b0;
      m_run[c] = 0; m_gt[c] = 0;
    end
    test_reset();
    test_debounce();
    test_gap();
    test_maxout();
    test_independence();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
